// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bus between the requesting channels (master) and the
// round-robin arbiter in front of the 3-to-8 decoder (slave).
interface rr_dec_arbiter_if;
  logic [7:0] req;        // level request per channel
  logic       done;       // one-cycle release pulse from current owner
  logic       gnt_valid;  // a grant is active
  logic [2:0] gnt_idx;    // decoder select: bit2=a, bit1=b, bit0=c
  logic [7:0] gnt;        // one-hot grant, decoder image of gnt_idx
  logic       timeout;    // grant forcibly revoked (hold limit)

  modport master (output req, done, input gnt_valid, gnt_idx, gnt, timeout);
  modport slave  (input req, done, output gnt_valid, gnt_idx, gnt, timeout);
endinterface

// File: rtl/rr_dec_arbiter.sv
// Eight-requester round-robin arbiter feeding a 3-to-8 decoder select.
// IDLE -> GRANT (held until release) -> GAP (one dead cycle) -> IDLE.
// Optional hold-limit timer enabled by defining ARB_TIMEOUT_EN; MAX_HOLD
// sets the number of GRANT cycles before a grant is revoked.
module rr_dec_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_dec_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] idx_r;
  logic [7:0] gnt_r;
  logic       vld_r;
  logic [2:0] win;
  logic       rel;
  logic       expire;

  // Reject an out-of-range hold limit at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
    $error("rr_dec_arbiter: MAX_HOLD out of range");
  end

  // First requester at or above ptr, wrapping 7->0 (smallest offset wins).
  always_comb begin
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr + 3'(k)]) win = ptr + 3'(k);
    end
  end

  // Owner release: explicit done or withdrawn request.
  assign rel = bus.done || !bus.req[idx_r];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold;
  logic        to_r;
  // Expiry on the edge that closes the MAX_HOLD-th GRANT cycle.
  assign expire      = (hold == 16'(MAX_HOLD - 1));
  assign bus.timeout = to_r;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_valid = vld_r;
  assign bus.gnt_idx   = idx_r;
  assign bus.gnt       = gnt_r;

  // Arbitration FSM with registered outputs; gnt_idx holds when no grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      idx_r <= 3'd0;
      gnt_r <= 8'h00;
      vld_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold  <= 16'd0;
      to_r  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req) begin
            idx_r <= win;
            gnt_r <= 8'b1 << win;
            vld_r <= 1'b1;
            ptr   <= win + 3'd1;
`ifdef ARB_TIMEOUT_EN
            hold  <= 16'd0;
`endif
            state <= GRANT;
          end else begin
            vld_r <= 1'b0;
            gnt_r <= 8'h00;
          end
        end
        GRANT: begin
`ifdef ARB_TIMEOUT_EN
          hold <= hold + 16'd1;
`endif
          if (rel || expire) begin
            vld_r <= 1'b0;
            gnt_r <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            to_r  <= expire && !rel;
`endif
            state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: directed vector table, hand-written
// fairness/timeout sequences, then randomized traffic against a cycle model.
module tb_rr_dec_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_dec_arbiter_if bus ();

  rr_dec_arbiter #(.MAX_HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: owner channel (-1 = none), dead cycles left, pointer.
  int m_owner, m_dead, m_ptr, m_held, m_idx, m_to;

  task automatic model_edge(input logic r, input logic [7:0] q, input logic d);
    int rl, ex;
    m_to = 0;
    if (!r) begin
      m_owner = -1; m_dead = 0; m_ptr = 0; m_held = 0; m_idx = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      rl = (d || !q[m_owner]) ? 1 : 0;
`ifdef ARB_TIMEOUT_EN
      ex = (m_held >= HOLD) ? 1 : 0;
`else
      ex = 0;
`endif
      if (rl || ex) begin
        m_to = (ex && !rl) ? 1 : 0;
        m_owner = -1;
        m_dead = 1;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (q != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      end
      m_idx  = m_owner;
      m_ptr  = (m_owner + 1) % 8;
      m_held = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs are already applied; sample 1 ns after the edge.
  task automatic step();
    logic r; logic [7:0] q; logic d;
    r = rst_n; q = bus.req; d = bus.done;
    @(posedge clk);
    #1;
    model_edge(r, q, d);
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic d);
    rst_n = r; bus.req = q; bus.done = d;
  endtask

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       d;
    logic       ev;
    logic [2:0] ei;
    logic [7:0] eg;
  } vec_t;

  vec_t tbl[24];

  task automatic setv(input int i, input logic r, input logic [7:0] q, input logic d,
                      input logic ev, input logic [2:0] ei, input logic [7:0] eg);
    tbl[i].r = r; tbl[i].q = q; tbl[i].d = d;
    tbl[i].ev = ev; tbl[i].ei = ei; tbl[i].eg = eg;
  endtask

  initial begin
    int exp_i;
    drive(1'b0, 8'hFF, 1'b0);
    bus.done = 1'b0;

    //        rst  req    done valid idx  gnt
    setv( 0, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00); // reset with all requests
    setv( 1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00);
    setv( 2, 1'b1, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20); // single request ch5
    setv( 3, 1'b1, 8'h20, 1'b1, 1'b0, 3'd5, 8'h00); // done -> GAP
    setv( 4, 1'b1, 8'h20, 1'b0, 1'b0, 3'd5, 8'h00); // IDLE, no grant yet
    setv( 5, 1'b1, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20); // earliest regrant
    setv( 6, 1'b1, 8'h09, 1'b1, 1'b0, 3'd5, 8'h00);
    setv( 7, 1'b1, 8'h09, 1'b0, 1'b0, 3'd5, 8'h00);
    setv( 8, 1'b1, 8'h09, 1'b0, 1'b1, 3'd0, 8'h01); // ptr=6 wraps to 0
    setv( 9, 1'b1, 8'h09, 1'b1, 1'b0, 3'd0, 8'h00);
    setv(10, 1'b1, 8'h09, 1'b0, 1'b0, 3'd0, 8'h00);
    setv(11, 1'b1, 8'h09, 1'b0, 1'b1, 3'd3, 8'h08); // then 3
    setv(12, 1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08); // others ignored
    setv(13, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00); // owner withdraws
    setv(14, 1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00); // done in IDLE ignored
    setv(15, 1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);
    setv(16, 1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04); // ptr=4 wraps to 2
    setv(17, 1'b1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00); // done + drop together
    setv(18, 1'b1, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00);
    setv(19, 1'b1, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00);
    setv(20, 1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10);
    setv(21, 1'b0, 8'h10, 1'b0, 1'b0, 3'd0, 8'h00); // reset mid-grant
    setv(22, 1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10);
    setv(23, 1'b1, 8'h10, 1'b1, 1'b0, 3'd4, 8'h00);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].q, tbl[i].d);
      step();
      chk($sformatf("vec%0d valid", i), int'(bus.gnt_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d idx", i), int'(bus.gnt_idx), int'(tbl[i].ei));
      chk($sformatf("vec%0d gnt", i), int'(bus.gnt), int'(tbl[i].eg));
      chk($sformatf("vec%0d timeout", i), int'(bus.timeout), 0);
    end

    // Fairness: all channels requesting, done after each grant.
    drive(1'b0, 8'hFF, 1'b0);
    step();
    for (int g = 0; g < 9; g++) begin
      drive(1'b1, 8'hFF, 1'b0);
      step();
      exp_i = g % 8;
      chk($sformatf("fair%0d valid", g), int'(bus.gnt_valid), 1);
      chk($sformatf("fair%0d idx", g), int'(bus.gnt_idx), exp_i);
      chk($sformatf("fair%0d gnt", g), int'(bus.gnt), 1 << exp_i);
      drive(1'b1, 8'hFF, 1'b1);
      step();
      chk($sformatf("fair%0d gap", g), int'(bus.gnt_valid), 0);
      drive(1'b1, 8'hFF, 1'b0);
      step();
      chk($sformatf("fair%0d idle", g), int'(bus.gnt_valid), 0);
    end

`ifdef ARB_TIMEOUT_EN
    // Hold limit: request held, no done; revoke after HOLD grant cycles.
    drive(1'b0, 8'h01, 1'b0);
    step();
    drive(1'b1, 8'h01, 1'b0);
    for (int c = 0; c < HOLD; c++) begin
      step();
      chk($sformatf("hold%0d valid", c), int'(bus.gnt_valid), 1);
      chk($sformatf("hold%0d timeout", c), int'(bus.timeout), 0);
    end
    step();
    chk("expire valid", int'(bus.gnt_valid), 0);
    chk("expire timeout", int'(bus.timeout), 1);
    step();
    chk("post-expire timeout", int'(bus.timeout), 0);
    chk("post-expire valid", int'(bus.gnt_valid), 0);
    step();
    chk("regrant valid", int'(bus.gnt_valid), 1);
    chk("regrant idx", int'(bus.gnt_idx), 0);
    drive(1'b0, 8'h01, 1'b0);
    step();
    chk("rst-in-grant valid", int'(bus.gnt_valid), 0);
    chk("rst-in-grant timeout", int'(bus.timeout), 0);
`endif

    // Randomized traffic against the model.
    drive(1'b0, 8'h00, 1'b0);
    step();
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] q;
      q = bus.req;
      if ($urandom_range(0, 3) == 0) q = 8'($urandom);
      if ($urandom_range(0, 15) == 0) q = 8'h00;
      drive(($urandom_range(0, 63) != 0), q, ($urandom_range(0, 3) == 0));
      step();
      chk($sformatf("rnd%0d valid", n), int'(bus.gnt_valid), (m_owner >= 0) ? 1 : 0);
      chk($sformatf("rnd%0d idx", n), int'(bus.gnt_idx), m_idx);
      chk($sformatf("rnd%0d gnt", n), int'(bus.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk($sformatf("rnd%0d timeout", n), int'(bus.timeout), m_to);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
